// File: rtl/bgu_serial_sub_pkg.sv
// Shared types and sizing helpers for the serial borrow-lookahead subtractor.
package bgu_serial_sub_pkg;

  // Controller states; encodings are fixed so debug views stay comparable.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned WidthDefault = 16;
  localparam int unsigned ChunkDefault = 4;

  // Index width for a chunk counter; a single-chunk build still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NCHUNK = WidthDefault / ChunkDefault;
  localparam int unsigned IDX_W  = idx_width(NCHUNK);

endpackage

// File: rtl/bgu_serial_sub_cla_slice.sv
// Combinational CHUNK-bit borrow-lookahead slice: difference, borrow out and
// group propagate/generate for cascading.
module bgu_cla_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_s,
  input  logic [CHUNK-1:0] b_s,
  input  logic             bin,
  output logic [CHUNK-1:0] d_s,
  output logic             bout,
  output logic             grp_p,
  output logic             grp_g
);

  // Each bit's borrow-in comes from the prefix group P/G of the bits below it.
  always_comb begin : lookahead
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] bin_v;
    logic             gacc;
    logic             pacc;
    g     = ~a_s & b_s;
    p     = ~(a_s ^ b_s);
    bin_v = '0;
    gacc  = 1'b0;
    pacc  = 1'b1;
    for (int i = 0; i < CHUNK; i++) begin
      bin_v[i] = gacc | (pacc & bin);
      gacc     = g[i] | (p[i] & gacc);
      pacc     = pacc & p[i];
    end
    d_s   = a_s ^ b_s ^ bin_v;
    grp_g = gacc;
    grp_p = pacc;
    bout  = gacc | (pacc & bin);
  end

endmodule

// File: rtl/bgu_serial_sub.sv
// Multi-cycle subtractor: one CHUNK-bit borrow-lookahead slice per clock,
// valid/ready on both operand and result sides.
module bgu_serial_sub
  import bgu_serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault,
  parameter int unsigned CHUNK = ChunkDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned IdxW   = idx_width(NChunk);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [CHUNK-1:0] a_s, b_s, d_s;
  logic             s_bout, s_p, s_g;

  bgu_cla_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a_s   (a_s),
    .b_s   (b_s),
    .bin   (bin_q),
    .d_s   (d_s),
    .bout  (s_bout),
    .grp_p (s_p),
    .grp_g (s_g)
  );

  // Group terms exist for cascading into a wider lookahead; one slice needs only bout.
  logic unused_grp;
  assign unused_grp = s_p ^ s_g;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (idx_q == LastIdx) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // Slice operand mux: pick the chunk addressed by idx_q.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int k = 0; k < int'(NChunk); k++) begin
      if (idx_q == IdxW'(k)) begin
        a_s = a_q[k*CHUNK +: CHUNK];
        b_s = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // Datapath next state: capture, per-slice accumulate, flags on the last slice.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          bin_d = 1'b0;
          idx_d = '0;
        end
      end
      StRun: begin
        for (int k = 0; k < int'(NChunk); k++) begin
          if (idx_q == IdxW'(k)) diff_d[k*CHUNK +: CHUNK] = d_s;
        end
        bin_d = s_bout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d    = '0;
          borrow_d = s_bout;
          zero_d   = (diff_d == '0);
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_bgu_serial_sub.sv
// Scoreboard bench for bgu_serial_sub: driver pushes model results, monitor
// pops and compares on every accepted output.
module tb_bgu_serial_sub;

  localparam int W   = 16;
  localparam int NCH = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow_out, ovf, zero;

  logic         bp_random = 1'b0;
  logic         bp_val = 1'b0;
  int           checks = 0;
  int           errors = 0;
  exp_t         sb_q[$];

  bgu_serial_sub #(
    .WIDTH (W),
    .CHUNK (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a_i),
    .b          (b_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on the mathematical values.
  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb);
    exp_t        m;
    int unsigned ua = va;
    int unsigned ub = vb;
    int          sa = int'($signed(va));
    int          sb = int'($signed(vb));
    int          r  = sa - sb;
    m.d  = W'(ua - ub);
    m.bo = (ua < ub);
    m.ov = (r > 32767) || (r < -32768);
    m.z  = (ua == ub);
    return m;
  endfunction

  // Consumer ready: random backpressure or a forced level.
  always @(posedge clk) begin
    #1 out_ready = bp_random ? ($urandom_range(0, 3) != 0) : bp_val;
  end

  // Monitor: compare every accepted result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 32'(diff), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("borrow_out", 32'(borrow_out), 32'(e.bo));
        chk("ovf", 32'(ovf), 32'(e.ov));
        chk("zero", 32'(zero), 32'(e.z));
      end
    end
  end

  // Issue one operation, scramble inputs after capture, and check latency.
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] pa);
    int n;
    @(negedge clk);
    a_i = va;
    b_i = vb;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    sb_q.push_back(model(va, vb));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_i = pa;
    b_i = ~vb;
    repeat (NCH - 1) @(posedge clk);
    #1 chk("latency_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 chk("latency_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    // Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_diff", 32'(diff), 32'd0);
    chk("idle_zero", 32'(zero), 32'd0);
    chk("idle_borrow", 32'(borrow_out), 32'd0);
    chk("idle_ovf", 32'(ovf), 32'd0);

    // Directed cases with an always-ready consumer.
    bp_val = 1'b1;
    send(16'h1234, 16'h0234, 16'h5555);
    send(16'h0000, 16'h0001, 16'h1111);
    send(16'h8000, 16'h0001, 16'h2222);
    send(16'h0000, 16'hFFFF, 16'h3333);
    send(16'h7FFF, 16'hFFFF, 16'h4444);
    send(16'h0010, 16'h0001, 16'hFFFF);
    drain();

    // Equal operands under five cycles of backpressure.
    bp_val = 1'b0;
    @(posedge clk);
    send(16'hBEEF, 16'hBEEF, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_diff", 32'(diff), 32'd0);
      chk("bp_zero", 32'(zero), 32'd1);
      chk("bp_borrow", 32'(borrow_out), 32'd0);
    end
    bp_val = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Reset during the second RUN cycle: nothing may be emitted.
    @(negedge clk);
    a_i = 16'h9999;
    b_i = 16'h1111;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_diff", 32'(diff), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    send(16'h0005, 16'h0003, 16'hAAAA);
    drain();

    // Random operands with random backpressure.
    bp_random = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i % 8 == 0) ? ra : W'($urandom);
      send(ra, rb, W'($urandom));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
